// File: rtl/add_serial2.sv
// Serial adder: sums two WIDTH-bit operands 2 bits per cycle through a registered carry, result valid WIDTH/2 cycles after accept.
// One operation in flight; DONE holds O/COUT and keeps I_READY low until the consumer raises O_READY.
module add_serial2 #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             CIN,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [WIDTH-1:0] O,
  output logic             COUT,
  output logic             O_VALID,
  input  logic             O_READY
);

  localparam int NSLICE = WIDTH / 2;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              carry;
  logic [IDXW-1:0]   idx;
  logic [1:0]        a_sl, b_sl;
  logic [2:0]        sum;
  logic              last;

  assign last = (idx == LAST_IDX);

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (I_VALID) state_nxt = RUN;
      RUN:     if (last)    state_nxt = DONE;
      DONE:    if (O_READY) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_comb begin
    I_READY = (state == IDLE);
    O_VALID = (state == DONE);
  end

  // Mux the current 2-bit slice out of each operand; one shared slice adder.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (idx == IDXW'(k)) begin
        a_sl = a_q[2*k +: 2];
        b_sl = b_q[2*k +: 2];
      end
    end
    sum = {1'b0, a_sl} + {1'b0, b_sl} + {2'b00, carry};
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      O     <= '0;
      COUT  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (I_VALID && I_READY) begin
            a_q   <= I0;
            b_q   <= I1;
            carry <= CIN;
            idx   <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < NSLICE; k++) begin
            if (idx == IDXW'(k)) O[2*k +: 2] <= sum[1:0];
          end
          carry <= sum[2];
          if (last) COUT <= sum[2];
          else      idx  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
